gprs_mp_bypass: RTL

Parametrised multi-port general-purpose register file for the pipelined processor, replacing the fixed 8x16, 2-read/1-write register file. It provides NUM_RD combinational read ports with same-cycle write-to-read bypass, two prioritised write ports (ALU and load writeback), optional hardwired-zero R0, and a per-register pending scoreboard that drives operand-busy flags for the hazard/stall logic.

---
 rtl/gprs_pkg.sv | 16 +
 rtl/gprs_rd_port.sv | 49 ++++
 rtl/gprs_mp_bypass.sv | 94 +++++++++
 3 files changed

// File: rtl/gprs_pkg.sv
// Shared defaults and the write-port bundle type for the multi-port register file.
package gprs_pkg;

   localparam int unsigned GPRS_DATA_W   = 16;
   localparam int unsigned GPRS_NUM_REGS = 8;
   localparam int unsigned GPRS_NUM_RD   = 2;
   localparam int unsigned GPRS_ADDR_W   = $clog2(GPRS_NUM_REGS);

   // Write-port bundle for parent-level plumbing (ALU / load writeback).
   typedef struct packed {
      logic                   en;
      logic [GPRS_ADDR_W-1:0] addr;
      logic [GPRS_DATA_W-1:0] data;
   } gprs_wr_t;

endpackage

// File: rtl/gprs_rd_port.sv
// One combinational read port: storage mux, write bypass (port 1 over port 0),
// zero/out-of-range masking and operand-busy flag.
module gprs_rd_port
   import gprs_pkg::*;
#(
   parameter int unsigned DATA_W   = GPRS_DATA_W,
   parameter int unsigned NUM_REGS = GPRS_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
   parameter bit          ZERO_R0  = 1'b0
) (
   input  logic              block_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr0_en_i,
   input  logic [ADDR_W-1:0] wr0_addr_i,
   input  logic [DATA_W-1:0] wr0_data_i,
   input  logic              wr1_en_i,
   input  logic [ADDR_W-1:0] wr1_addr_i,
   input  logic [DATA_W-1:0] wr1_data_i,
   input  logic [DATA_W-1:0] regs_i [NUM_REGS],
   input  logic [NUM_REGS-1:0] pending_i,
   output logic [DATA_W-1:0] rd_data_c_o,
   output logic              rd_busy_c_o
);

   logic addr_ok;
   logic hit0;
   logic hit1;

   always_comb begin
      rd_data_c_o = '0;
      rd_busy_c_o = 1'b0;
      addr_ok     = !block_i && (32'(rd_addr_i) < NUM_REGS) &&
                    !(ZERO_R0 && (rd_addr_i == '0));
      hit1        = wr1_en_i && (wr1_addr_i == rd_addr_i);
      hit0        = wr0_en_i && (wr0_addr_i == rd_addr_i);
      if (addr_ok) begin
         if (hit1) begin
            rd_data_c_o = wr1_data_i;
         end else if (hit0) begin
            rd_data_c_o = wr0_data_i;
         end else begin
            rd_data_c_o = regs_i[rd_addr_i];
         end
         // A writeback landing this cycle resolves the hazard via the bypass.
         rd_busy_c_o = pending_i[rd_addr_i] && !(hit0 || hit1);
      end
   end

endmodule

// File: rtl/gprs_mp_bypass.sv
// Multi-port register file with two prioritised write ports, same-cycle bypass,
// optional hardwired-zero R0 and a per-register pending scoreboard.
module gprs_mp_bypass
   import gprs_pkg::*;
#(
   parameter int unsigned DATA_W   = GPRS_DATA_W,
   parameter int unsigned NUM_REGS = GPRS_NUM_REGS,
   parameter int unsigned NUM_RD   = GPRS_NUM_RD,
   parameter bit          ZERO_R0  = 1'b0,
   localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic                wr0_ok;
   logic                wr1_ok;
   logic                iss_ok;

   // Drop accesses to out-of-range addresses and to a hardwired-zero R0.
   always_comb begin
      wr0_ok = wr0_en && (32'(wr0_addr) < NUM_REGS) && !(ZERO_R0 && (wr0_addr == '0));
      wr1_ok = wr1_en && (32'(wr1_addr) < NUM_REGS) && !(ZERO_R0 && (wr1_addr == '0));
      iss_ok = iss_en && (32'(iss_addr) < NUM_REGS) && !(ZERO_R0 && (iss_addr == '0));
   end

   // Port 1 applied last so it wins a collision; issue applied last so a new
   // producer supersedes a same-cycle writeback.
   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      if (wr0_ok) begin
         regs_d[wr0_addr]    = wr0_data;
         pending_d[wr0_addr] = 1'b0;
      end
      if (wr1_ok) begin
         regs_d[wr1_addr]    = wr1_data;
         pending_d[wr1_addr] = 1'b0;
      end
      if (iss_ok) begin
         pending_d[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      gprs_rd_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .ZERO_R0  (ZERO_R0)
      ) u_rd_port (
         .block_i     (reset),
         .rd_addr_i   (rd_addr[k*ADDR_W +: ADDR_W]),
         .wr0_en_i    (wr0_ok),
         .wr0_addr_i  (wr0_addr),
         .wr0_data_i  (wr0_data),
         .wr1_en_i    (wr1_ok),
         .wr1_addr_i  (wr1_addr),
         .wr1_data_i  (wr1_data),
         .regs_i      (regs_q),
         .pending_i   (pending_q),
         .rd_data_c_o (rd_data[k*DATA_W +: DATA_W]),
         .rd_busy_c_o (rd_busy[k])
      );
   end

endmodule
